// File: rtl/button_pkg.sv
// Shared types and constants for the emulated raw push-button path:
// FSM encoding, bounce/settle timings, and the jitter LFSR definition.
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Also used as debounce thresholds by button_process_unit.
  localparam int unsigned HALF_HW    = 50000;
  localparam int unsigned HALF_SIM   = 5;
  localparam int unsigned SETTLE_HW  = 1000000;
  localparam int unsigned SETTLE_SIM = 100;

  // x^8 + x^6 + x^5 + x^4 + 1, right-shifting Galois form.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_lfsr8.sv
// 8-bit Galois LFSR with advance enable; a nonzero seed keeps it out of
// the all-zero lock-up state.
module button_lfsr8
  import button_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED,
  parameter logic [7:0] TAPS = LFSR_TAPS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  output logic [7:0] value
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) begin
      lfsr_d = {1'b0, lfsr_q[7:1]};
      if (lfsr_q[0]) lfsr_d = lfsr_d ^ TAPS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/button_bounce_emulator.sv
// Mechanical push-button emulator: converts a clean level request into a
// registered, bouncing ButtonOut waveform followed by a settle period and done.
module button_bounce_emulator #(
  parameter int unsigned sim         = 1,
  parameter int unsigned N_BOUNCES   = 25,
  parameter int unsigned HALF_HW     = button_pkg::HALF_HW,
  parameter int unsigned HALF_SIM    = button_pkg::HALF_SIM,
  parameter int unsigned SETTLE_HW   = button_pkg::SETTLE_HW,
  parameter int unsigned SETTLE_SIM  = button_pkg::SETTLE_SIM,
  parameter int unsigned RANDOM      = 0,
  parameter logic [7:0]  JITTER_MASK = 8'h03,
  parameter logic        IDLE_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic cmd_valid,
  input  logic cmd_level,
  output logic cmd_ready,
  output logic ButtonOut,
  output logic busy,
  output logic done
);
  import button_pkg::*;

  localparam int unsigned HALF       = (sim != 0) ? HALF_SIM : HALF_HW;
  localparam int unsigned SETTLE     = (sim != 0) ? SETTLE_SIM : SETTLE_HW;
  localparam int unsigned CNT_W      = $clog2(max_u(HALF + int'(JITTER_MASK), SETTLE) + 1);
  localparam int unsigned TOG_TOTAL  = 2 * N_BOUNCES;
  localparam int unsigned TOG_W      = max_u($clog2(TOG_TOTAL + 1), 1);
  localparam int unsigned TOG_LAST   = (TOG_TOTAL > 0) ? TOG_TOTAL - 1 : 0;
  localparam logic        USE_JITTER = (RANDOM != 0);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TOG_W-1:0]   tog_q, tog_d;
  logic               bo_q, bo_d;
  logic               lfsr_adv;
  logic [7:0]         lfsr_val;
  logic [CNT_W-1:0]   seg_load;
  logic [CNT_W-1:0]   settle_load;

  button_lfsr8 #(
    .SEED (LFSR_SEED),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (reset),
    .advance (lfsr_adv),
    .value   (lfsr_val)
  );

  // Counters are loaded with length-1 so the edge lands exactly 'length'
  // cycles after the previous one.
  always_comb begin
    seg_load = CNT_W'(HALF - 1);
    if (USE_JITTER) seg_load = seg_load + CNT_W'(lfsr_val & JITTER_MASK);
    settle_load = CNT_W'(SETTLE - 1);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tog_d    = tog_q;
    bo_d     = bo_q;
    lfsr_adv = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_level == bo_q) begin
            state_d = ST_DONE;
          end else begin
            bo_d  = cmd_level;
            tog_d = '0;
            if (TOG_TOTAL == 0) begin
              state_d = ST_SETTLE;
              cnt_d   = settle_load;
            end else begin
              state_d  = ST_BOUNCE;
              cnt_d    = seg_load;
              lfsr_adv = USE_JITTER;
            end
          end
        end
      end
      ST_BOUNCE: begin
        if (cnt_q == '0) begin
          bo_d  = ~bo_q;
          tog_d = tog_q + TOG_W'(1);
          if (tog_q == TOG_W'(TOG_LAST)) begin
            state_d = ST_SETTLE;
            cnt_d   = settle_load;
          end else begin
            cnt_d    = seg_load;
            lfsr_adv = USE_JITTER;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tog_q   <= '0;
      bo_q    <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      bo_q    <= bo_d;
    end
  end

  assign ButtonOut = bo_q;
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_button_bounce_emulator.sv
// Directed bench: deterministic instance (A) and jittered instance (B),
// with a negedge monitor recording edge timing and done pulses per instance.
module tb_button_bounce_emulator;

  logic clk = 1'b0;
  logic reset;
  logic va, la, ra, boa, ba, da;
  logic vb, lb, rb, bob, bb, db;

  always #5 clk = ~clk;

  button_bounce_emulator #(
    .sim (1), .N_BOUNCES (25), .RANDOM (0), .JITTER_MASK (8'h03), .IDLE_LEVEL (1'b0)
  ) dut_a (
    .clk (clk), .reset (reset), .cmd_valid (va), .cmd_level (la),
    .cmd_ready (ra), .ButtonOut (boa), .busy (ba), .done (da)
  );

  button_bounce_emulator #(
    .sim (1), .N_BOUNCES (25), .RANDOM (1), .JITTER_MASK (8'h03), .IDLE_LEVEL (1'b0)
  ) dut_b (
    .clk (clk), .reset (reset), .cmd_valid (vb), .cmd_level (lb),
    .cmd_ready (rb), .ButtonOut (bob), .busy (bb), .done (db)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int run_id [2] = '{0, 0};
  int seen_id[2] = '{0, 0};
  int edges[2], first_e[2], last_e[2], min_g[2], max_g[2], dcnt[2], dcyc[2];
  logic prev[2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    logic cur [2];
    logic dn [2];
    cur[0] = boa; cur[1] = bob;
    dn[0]  = da;  dn[1]  = db;
    for (int i = 0; i < 2; i++) begin
      if (run_id[i] != seen_id[i]) begin
        seen_id[i] = run_id[i];
        edges[i] = 0; first_e[i] = -1; last_e[i] = -1;
        min_g[i] = 1000000; max_g[i] = 0; dcnt[i] = 0; dcyc[i] = -1;
      end
      if (cur[i] !== prev[i]) begin
        if (edges[i] == 0) first_e[i] = cyc;
        else begin
          if (cyc - last_e[i] < min_g[i]) min_g[i] = cyc - last_e[i];
          if (cyc - last_e[i] > max_g[i]) max_g[i] = cyc - last_e[i];
        end
        last_e[i] = cyc;
        edges[i]++;
      end
      if (dn[i] === 1'b1) begin
        dcnt[i]++;
        dcyc[i] = cyc;
      end
      prev[i] = cur[i];
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int kc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic lvl);
    step();
    run_id[i]++;
    kc = cyc;
    if (i == 0) begin va = 1'b1; la = lvl; end
    else        begin vb = 1'b1; lb = lvl; end
    step();
    va = 1'b0;
    vb = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (dcnt[i] > 0) break;
      step();
    end
    if (dcnt[i] == 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b0;
    va = 1'b0; la = 1'b0; vb = 1'b0; lb = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_bo",    boa, 0);
    chk("rst_ready", ra,  1);
    chk("rst_busy",  ba,  0);
    chk("rst_done",  da,  0);
    chk("rst_bo_b",  bob, 0);
    reset = 1'b1;

    // Press with a rejected release request in the middle of bouncing.
    issue(0, 1'b1);
    chk("press_bo_k1",    boa, 1);
    chk("press_busy_k1",  ba,  1);
    chk("press_ready_k1", ra,  0);
    repeat (20) step();
    va = 1'b1; la = 1'b0;
    step();
    va = 1'b0;
    wait_done(0, 1000);
    chk("press_done_cyc", dcyc[0],  kc + 351);
    chk("press_edges",    edges[0], 51);
    chk("press_first",    first_e[0], kc + 1);
    chk("press_last",     last_e[0],  kc + 251);
    chk("press_min_gap",  min_g[0], 5);
    chk("press_max_gap",  max_g[0], 5);
    chk("press_level",    boa, 1);
    step();
    chk("press_ready_after", ra, 1);
    chk("press_done_width",  da, 0);
    chk("press_done_count",  dcnt[0], 1);

    // Release.
    issue(0, 1'b0);
    chk("rel_bo_k1", boa, 0);
    wait_done(0, 1000);
    chk("rel_done_cyc", dcyc[0],    kc + 351);
    chk("rel_edges",    edges[0],   51);
    chk("rel_last",     last_e[0],  kc + 251);
    chk("rel_min_gap",  min_g[0],   5);
    chk("rel_max_gap",  max_g[0],   5);
    chk("rel_level",    boa, 0);

    // Same-level request: immediate done, no edges.
    issue(0, 1'b0);
    chk("same_done_k1", da, 1);
    chk("same_busy_k1", ba, 1);
    chk("same_ready_k1", ra, 0);
    repeat (5) step();
    chk("same_edges",    edges[0], 0);
    chk("same_done_cnt", dcnt[0], 1);
    chk("same_done_cyc", dcyc[0], kc + 1);
    chk("same_ready",    ra, 1);

    // Jittered press.
    issue(1, 1'b1);
    chk("rnd_bo_k1", bob, 1);
    wait_done(1, 2000);
    chk("rnd_edges",      edges[1], 51);
    chk("rnd_min_ge5",    min_g[1] >= 5, 1);
    chk("rnd_max_le8",    max_g[1] <= 8, 1);
    chk("rnd_jitter_seen", max_g[1] > 5, 1);
    chk("rnd_level",      bob, 1);
    chk("rnd_settle",     dcyc[1] - last_e[1], 100);
    chk("rnd_first",      first_e[1], kc + 1);

    // Asynchronous reset while bouncing; no resume afterwards.
    issue(0, 1'b1);
    repeat (12) step();
    chk("abort_pre_bo", boa, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_bo",    boa, 0);
    chk("abort_busy",  ba,  0);
    chk("abort_ready", ra,  1);
    chk("abort_done",  da,  0);
    step();
    reset = 1'b1;
    run_id[0]++;
    repeat (20) step();
    chk("abort_no_resume_bo",    boa, 0);
    chk("abort_no_resume_edges", edges[0], 0);
    chk("abort_no_resume_done",  dcnt[0], 0);
    chk("abort_ready_after",     ra, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
